lsu_mem_ctrl: RTL
=================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 32, number of 32-bit words in the attached data memory (power of 2).
REQ-002 SHALL have `clk`, input, 1, clock; all state changes on rising edge.
REQ-003 SHALL have `reset`, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have `req_valid`, input, 1, core load/store request present.
REQ-005 SHALL have `req_ready`, output, 1, controller accepts request this cycle.
REQ-006 SHALL have `req_we`, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have `req_funct3`, input, 3, RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have `req_addr`, input, 32, byte address.
REQ-009 SHALL have `req_wdata`, input, 32, store data, LSB-aligned.
REQ-010 SHALL have `resp_valid`, output, 1, response available.
REQ-011 SHALL have `resp_ready`, input, 1, core accepts response.
REQ-012 SHALL have `resp_rdata`, output, 32, load result after extension; 0 for stores and errors.
REQ-013 SHALL have `resp_err`, output, 1, misaligned, out-of-range or illegal funct3.
REQ-014 SHALL have `mem_addr`, output, 32, word index to memory.
REQ-015 SHALL have `mem_wr_en`, output, 1, memory write strobe.
REQ-016 SHALL have `mem_wr_data`, output, 32, full word to write.
REQ-017 SHALL have `mem_rd_en`, output, 1, memory read enable.
REQ-018 SHALL have `mem_rd_data`, input, 32, memory read data, combinational from `mem_addr`.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-020 SHALL assert `req_ready` only in IDLE; a request is accepted when `req_valid` and `req_ready` are both 1 on a clock edge.
REQ-021 SHALL latch `req_we`, `req_funct3`, `req_addr` and `req_wdata` on acceptance; later changes on `req_*` SHALL have no effect.
REQ-022 SHALL flag an error for any of: H/HU with addr[0]=1; W with addr[1:0]≠0; funct3 011, 110 or 111; stores with funct3 bit2=1; word index ≥ DEPTH_WORDS.
REQ-023 SHALL send an erroring request from IDLE directly to RESP, with `resp_err`=1 and no memory strobe.
REQ-024 SHALL drive `mem_addr` = latched addr[31:2] in READ and WRITE; 0 otherwise.
REQ-025 SHALL transition IDLE→READ→RESP for loads; in READ, `mem_rd_en`=1 and `mem_rd_data` is captured at the exiting edge.
REQ-026 SHALL extract the load lane by addr[1:0] (byte) or addr[1] (half), then sign-extend (B, H) or zero-extend (BU, HU); W passes the captured word unchanged.
REQ-027 SHALL transition IDLE→WRITE→RESP for SW, with `mem_wr_data` = `req_wdata`.
REQ-028 SHALL transition IDLE→READ→WRITE→RESP for SB/SH (read-modify-write): only the addressed lane is replaced with `wdata`[7:0] or [15:0]; the other bytes come from the captured read word.
REQ-029 SHALL hold `mem_wr_en` high for exactly one cycle, in WRITE only; `mem_rd_en` SHALL be high in READ only; the two SHALL never be high together.
REQ-030 SHALL hold `resp_valid`=1, `resp_rdata` and `resp_err` stable in RESP until `resp_ready`=1, then go to IDLE; `req_ready` SHALL be 0 throughout RESP.
REQ-031 SHALL give a best-case request-accept to `resp_valid` latency of: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, error 1 cycle.

Reset
REQ-032 SHALL, while `reset`=1, force IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0.
REQ-033 SHALL, if reset occurs mid-operation (including between READ and WRITE of an RMW), abandon the request with no further memory write and no response.

Verification
REQ-034 SHALL cover: mem[1]=0x8899AABB, LB addr 0x6 → `resp_rdata`=0xFFFFFF99 two cycles after accept; LBU → 0x00000099.
REQ-035 SHALL cover: mem[2]=0x11223344, SH addr 0xA with wdata 0x0000BEEF → single write of 0xBEEF3344 to index 2; `resp_err`=0.
REQ-036 SHALL cover: LW addr 0x5 → `resp_valid` one cycle after accept, `resp_err`=1, `rdata`=0, no `mem_rd_en`/`mem_wr_en` pulse; also LW addr 0x80 with DEPTH=32 → `resp_err`=1.
REQ-037 SHALL cover: `resp_ready` held 0 for 3 cycles after LW addr 0x4 → `resp_valid` and `rdata` stable, `req_ready`=0 throughout; accept occurs on the 4th cycle.
REQ-038 SHALL cover: reset asserted in WRITE of SB → `mem_wr_en` drops immediately, memory unchanged, and the controller returns to IDLE with `req_ready`=1.
REQ-039 SHALL cover: SW addr 0x0 data 0xDEADBEEF, then LW addr 0x0 back-to-back → `rdata`=0xDEADBEEF.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: RV32I byte/half/word accesses onto a
// single-ported word memory, with read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data
);

  localparam int unsigned IDX_W = 30;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;

  logic             w_mis, w_f3_bad, w_oor, w_req_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_shift, w_load, w_merge;

  // State and latched request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_we     <= w_we_nxt;
      r_funct3 <= w_funct3_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_err    <= w_err_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  // Request legality, load extraction, sub-word merge, next state, outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_we_nxt     = r_we;
    w_funct3_nxt = r_funct3;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_err_nxt    = r_err;
    w_rdata_nxt  = r_rdata;
    w_mis        = 1'b0;
    w_f3_bad     = 1'b0;

    w_idx = req_addr[31:2];
    w_oor = (w_idx >= IDX_W'(DEPTH_WORDS));
    case (req_funct3)
      3'b000: w_mis = 1'b0;
      3'b001: w_mis = req_addr[0];
      3'b010: w_mis = |req_addr[1:0];
      3'b100: w_f3_bad = req_we;
      3'b101: begin
        w_mis    = req_addr[0];
        w_f3_bad = req_we;
      end
      default: w_f3_bad = 1'b1;
    endcase
    w_req_err = w_mis | w_f3_bad | w_oor;

    w_rd_shift = mem_rd_data >> {r_addr[1:0], 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
      3'b100:  w_load = {24'd0, w_rd_shift[7:0]};
      3'b001:  w_load = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
      3'b101:  w_load = {16'd0, w_rd_shift[15:0]};
      default: w_load = mem_rd_data;
    endcase

    w_merge = mem_rd_data;
    if (r_funct3[1:0] == 2'b00) w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else                        w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_we_nxt     = req_we;
          w_funct3_nxt = req_funct3;
          w_addr_nxt   = req_addr;
          w_wdata_nxt  = req_wdata;
          w_err_nxt    = w_req_err;
          w_rdata_nxt  = 32'd0;
          if (w_req_err)                         w_state_nxt = S_RESP;
          else if (req_we && req_funct3 == 3'b010) w_state_nxt = S_WRITE;
          else                                   w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (r_we) begin
          w_wdata_nxt = w_merge;
          w_state_nxt = S_WRITE;
        end else begin
          w_rdata_nxt = w_load;
          w_state_nxt = S_RESP;
        end
      end
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    req_ready   = (r_state == S_IDLE);
    mem_rd_en   = (r_state == S_READ);
    mem_wr_en   = (r_state == S_WRITE);
    mem_addr    = (mem_rd_en || mem_wr_en) ? {2'b00, r_addr[31:2]} : 32'd0;
    mem_wr_data = mem_wr_en ? r_wdata : 32'd0;
    resp_valid  = (r_state == S_RESP);
    resp_rdata  = resp_valid ? r_rdata : 32'd0;
    resp_err    = resp_valid & r_err;
  end

endmodule
